// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encodings,
// counter widths and a parameter sanity helper.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BUBBLE  = 2'd1,
    ST_MULBUSY = 2'd2
  } state_e;

  localparam int STALL_W = 16;

  // True when a cnt_w-bit down-counter can hold the larger of the two preloads.
  function automatic bit cnt_fits(input int cnt_w, input int raw_bubbles, input int mul_lat);
    int max_v;
    max_v = (raw_bubbles > mul_lat) ? raw_bubbles : mul_lat;
    return ((1 << cnt_w) > max_v);
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_stall_counter.sv
// Saturating up-counter of stalled cycles; cleared asynchronously by reset
// and frozen at all-ones once full.
module stall_counter
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int W = STALL_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: converts one-cycle hazard
// requests into freeze/bubble sequences driving PC, IF/ID and ID/EX controls.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int RAW_BUBBLES = 2,
  parameter int MUL_LAT     = 4,
  parameter int CNT_W       = 3
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               LoadUse,
  input  logic               RawHazard,
  input  logic               BranchTaken,
  input  logic               MulIssue,
  output logic               PCWrite,
  output logic               IF_ID_Write,
  output logic               IF_ID_Flush,
  output logic               ID_EX_Flush,
  output logic               Busy,
  output logic [STALL_W-1:0] StallCount,
  output logic [1:0]         DbgState
);

  if (RAW_BUBBLES < 1 || MUL_LAT < 1 || !cnt_fits(CNT_W, RAW_BUBBLES, MUL_LAT)) begin : g_bad_params
    $error("pipeline_stall_ctrl: RAW_BUBBLES/MUL_LAT must be >=1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] RAW_INIT = CNT_W'(RAW_BUBBLES - 1);
  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic pc_write, if_id_write, if_id_flush, id_ex_flush;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (BranchTaken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (MulIssue) begin
          // The multiply itself proceeds into EX, so ID/EX is not bubbled here.
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          if (MUL_LAT > 1) begin
            state_d = ST_MULBUSY;
            cnt_d   = MUL_INIT;
          end
        end else if (RawHazard) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          if (RAW_BUBBLES > 1) begin
            state_d = ST_BUBBLE;
            cnt_d   = RAW_INIT;
          end
        end else if (LoadUse) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      ST_BUBBLE: begin
        if (BranchTaken) begin
          // The stalled instruction is squashed, so the remaining bubbles are moot.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = ST_RUN;
          cnt_d       = '0;
        end else begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          cnt_d       = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = ST_RUN;
        end
      end
      ST_MULBUSY: begin
        // The multiply is older than any branch, so the freeze always completes.
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
        if_id_flush = BranchTaken;
        cnt_d       = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign PCWrite     = Rst ? 1'b0 : pc_write;
  assign IF_ID_Write = Rst ? 1'b0 : if_id_write;
  assign IF_ID_Flush = Rst ? 1'b1 : if_id_flush;
  assign ID_EX_Flush = Rst ? 1'b1 : id_ex_flush;
  assign Busy        = (state_q != ST_RUN);
  assign DbgState    = state_q;

  stall_counter #(.W(STALL_W)) u_stall_counter (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .inc_i   (!Rst && !pc_write),
    .count_o (StallCount)
  );

endmodule
